alu_pipe: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle ALU: WIDTH-bit integer ALU

---
 rtl/alu_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with registered result, {N,Z,C,V} flags and tag passthrough.
// Optional feature macro ALU_MUL_EN adds an iterative shift-add multiplier on opcode 1010.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MUL  = 4'b1010
    } op_e;

    logic [SH_W-1:0]  shamt;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_rd;
    logic             alu_c;
    logic             alu_v;
    logic             accept;
    logic             wb_alu;
    logic             idle;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic [SH_W:0]    cnt_q, cnt_d;
    logic             is_mul;
    logic             mul_done;

    assign idle   = (state_q == S_IDLE);
    assign wb_alu = accept && !is_mul;
`else
    assign idle   = 1'b1;
    assign wb_alu = accept;
`endif

    assign in_ready = idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        shamt    = rs2[SH_W-1:0];
        add_full = {1'b0, rs1} + {1'b0, rs2};
        sub_full = {1'b0, rs1} + {1'b0, ~rs2} + {{WIDTH{1'b0}}, 1'b1};
        alu_rd   = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        err_d    = 1'b0;
`ifdef ALU_MUL_EN
        is_mul   = 1'b0;
`endif
        case (op_e'(op))
            OP_ADD: begin
                alu_rd = add_full[WIDTH-1:0];
                alu_c  = add_full[WIDTH];
                alu_v  = (rs1[WIDTH-1] == rs2[WIDTH-1]) && (add_full[WIDTH-1] != rs1[WIDTH-1]);
            end
            // Carry out of rs1 + ~rs2 + 1 is the inverted borrow.
            OP_SUB: begin
                alu_rd = sub_full[WIDTH-1:0];
                alu_c  = sub_full[WIDTH];
                alu_v  = (rs1[WIDTH-1] != rs2[WIDTH-1]) && (sub_full[WIDTH-1] != rs1[WIDTH-1]);
            end
            OP_AND:  alu_rd = rs1 & rs2;
            OP_OR:   alu_rd = rs1 | rs2;
            OP_XOR:  alu_rd = rs1 ^ rs2;
            OP_SLT:  alu_rd = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLTU: alu_rd = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            OP_SLL:  alu_rd = rs1 << shamt;
            OP_SRL:  alu_rd = rs1 >> shamt;
            OP_SRA:  alu_rd = $unsigned($signed(rs1) >>> shamt);
`ifdef ALU_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: err_d = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    // Edges 1..WIDTH each consume one multiplier bit; the following edge writes the result.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mtag_d   = mtag_q;
        cnt_d    = cnt_q;
        mul_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = S_MUL;
                    mcand_d  = rs1;
                    mplier_d = rs2;
                    acc_d    = '0;
                    mtag_d   = in_tag;
                    cnt_d    = '0;
                end
            end
            S_MUL: begin
                if (cnt_q == (SH_W+1)'(WIDTH)) begin
                    mul_done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mtag_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mtag_q   <= mtag_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        out_tag_d   = out_tag_q;
        flags_d     = flags_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (wb_alu) begin
            out_valid_d = 1'b1;
            rd_d        = alu_rd;
            out_tag_d   = in_tag;
            flags_d     = {alu_rd[WIDTH-1], (alu_rd == '0), alu_c, alu_v};
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            out_valid_d = 1'b1;
            rd_d        = acc_q;
            out_tag_d   = mtag_q;
            flags_d     = {acc_q[WIDTH-1], (acc_q == '0), 2'b00};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            out_tag_q   <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            out_tag_q   <= out_tag_d;
            flags_q     <= flags_d;
`ifdef ALU_MUL_EN
            if (wb_alu || mul_done) begin
                err_q <= wb_alu ? err_d : 1'b0;
            end
`else
            if (wb_alu) begin
                err_q <= err_d;
            end
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, back-pressure, streaming and random ops
// scored against a 64-bit arithmetic reference model; MUL paths follow ALU_MUL_EN.
`timescale 1ns/1ps
module tb_alu_pipe;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  rs2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  rd;
    logic [TW-1:0] out_tag;
    logic [3:0]    flags;
    logic          err;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .out_tag(out_tag), .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  rd;
        logic [3:0]    flags;
        logic          err;
        logic [TW-1:0] tag;
        int unsigned   lat;
        int unsigned   acc_cyc;
        bit            seen;
    } exp_t;

    exp_t          sb[$];
    int unsigned   total = 0;
    int unsigned   bad = 0;
    int unsigned   cyc = 0;
    int unsigned   rel_cnt = 0;
    int unsigned   last_acc_cyc = 0;
    int unsigned   last_rel_cyc = 0;
    bit            mul_busy = 1'b0;
    bit            rdy_mode = 1'b0;
    logic [W-1:0]  last_rd = '0;
    logic [3:0]    last_flags = '0;
    logic          last_err = 1'b0;
    logic [TW-1:0] last_tag = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] t);
        exp_t              e;
        longint unsigned   ua = 64'(a);
        longint unsigned   ub = 64'(b);
        longint unsigned   r = 0;
        longint unsigned   mask = (64'd1 << W) - 1;
        longint            sa = longint'($signed(a));
        longint            sbv = longint'($signed(b));
        longint            one = 1;
        longint            smax = (one << (W - 1)) - 1;
        longint            smin = -(one << (W - 1));
        longint            s;
        int unsigned       sh = b % W;
        bit                c = 1'b0;
        bit                v = 1'b0;
        bit                il = 1'b0;
        bit                mul = 1'b0;
        case (o)
            4'h0: begin r = ua + ub; c = (r >> W) != 0; s = sa + sbv; v = (s > smax) || (s < smin); end
            4'h1: begin r = ua - ub; c = (ua >= ub);    s = sa - sbv; v = (s > smax) || (s < smin); end
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ua ^ ub;
            4'h5: r = (sa < sbv) ? 1 : 0;
            4'h9: r = (ua < ub) ? 1 : 0;
            4'h6: r = ua << sh;
            4'h7: r = ua >> sh;
            4'h8: r = $unsigned(sa >>> sh);
`ifdef ALU_MUL_EN
            4'ha: begin r = ua * ub; mul = 1'b1; end
`endif
            default: il = 1'b1;
        endcase
        r         = r & mask;
        e.rd      = r[W-1:0];
        e.flags   = {e.rd[W-1], (e.rd == 0), c, v};
        e.err     = il;
        e.tag     = t;
        e.lat     = mul ? W + 1 : 1;
        e.acc_cyc = 0;
        e.seen    = 1'b0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t m;
        if (!reset) begin
            if (out_valid) begin
                mul_busy = 1'b0;
                if (sb.size() == 0) begin
                    check("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    m = sb[0];
                    if (!m.seen) begin
                        check("latency", 64'(cyc - m.acc_cyc), 64'(m.lat));
                        sb[0].seen = 1'b1;
                    end
                    check("rd", 64'(rd), 64'(m.rd));
                    check("flags", 64'(flags), 64'(m.flags));
                    check("err", 64'(err), 64'(m.err));
                    check("tag", 64'(out_tag), 64'(m.tag));
                    if (out_ready) begin
                        last_rd = rd; last_flags = flags; last_err = err; last_tag = out_tag;
                        void'(sb.pop_front());
                        rel_cnt++;
                        last_rel_cyc = cyc;
                    end
                end
            end
            check("in_ready", 64'(in_ready), 64'(!mul_busy && (!out_valid || out_ready)));
            if (in_valid && in_ready) begin
                m = model(op, rs1, rs2, in_tag);
                m.acc_cyc = cyc;
                sb.push_back(m);
                last_acc_cyc = cyc;
`ifdef ALU_MUL_EN
                if (op == 4'ha) mul_busy = 1'b1;
`endif
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t);
        int unsigned n = 0;
        op = o; rs1 = a; rs2 = b; in_tag = t; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 2000) begin
                check("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
                break;
            end
        end
        #1;
    endtask

    task automatic send_chk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [TW-1:0] t, input logic [W-1:0] erd,
                            input logic [3:0] efl, input logic eerr);
        send(o, a, b, t);
        drain();
        check("dir_rd", 64'(last_rd), 64'(erd));
        check("dir_flags", 64'(last_flags), 64'(efl));
        check("dir_err", 64'(last_err), 64'(eerr));
        check("dir_tag", 64'(last_tag), 64'(t));
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned f;
        int unsigned r0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        #20;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send_chk(4'h0, 71, 82, 4'h5, 153, 4'b0000, 1'b0);
        send_chk(4'h1, 16, 3, 4'h6, 13, 4'b0010, 1'b0);
        send_chk(4'h1, 3, 16, 4'h7, 32'hFFFF_FFF3, 4'b1000, 1'b0);
        send_chk(4'h0, 32'h7FFF_FFFF, 1, 4'h8, 32'h8000_0000, 4'b1001, 1'b0);
        send_chk(4'h6, 16, 8, 4'h9, 4096, 4'b0000, 1'b0);
        send_chk(4'h7, 24, 8, 4'hA, 0, 4'b0100, 1'b0);
        send_chk(4'h8, 32'h8000_0000, 4, 4'hB, 32'hF800_0000, 4'b1000, 1'b0);
        send_chk(4'h6, 1, 40, 4'hC, 256, 4'b0000, 1'b0);
        send_chk(4'hF, 5, 6, 4'hD, 0, 4'b0100, 1'b1);
`ifdef ALU_MUL_EN
        send_chk(4'hA, 7, 9, 4'hE, 63, 4'b0000, 1'b0);
        send_chk(4'hA, 32'hFFFF_FFFF, 2, 4'h1, 32'hFFFF_FFFE, 4'b1000, 1'b0);
`else
        send_chk(4'hA, 7, 9, 4'hE, 0, 4'b0100, 1'b1);
`endif

        // Back-pressure: result held, input stalled, then release and accept on one edge.
        out_ready = 1'b0;
        send(4'h0, 1, 2, 4'h3);
        op = 4'h2; rs1 = 32'hF0F0; rs2 = 32'hFF00; in_tag = 4'h4; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_same_edge", 64'(in_valid && in_ready && out_valid && out_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        r0 = rel_cnt;
        send(4'h0, 1, 1, 4'h0);
        f = last_acc_cyc;
        for (int i = 1; i < 8; i++) begin
            send(4'(i % 10), $urandom, $urandom, 4'(i));
        end
        check("stream_acc_span", 64'(last_acc_cyc - f), 64'd7);
        drain();
        check("stream_rel_cnt", 64'(rel_cnt - r0), 64'd8);
        check("stream_rel_span", 64'(last_rel_cyc - f), 64'd8);

        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), 4'($urandom));
        end
        rdy_mode = 1'b0;
        out_ready = 1'b1;
        drain();

`ifdef ALU_MUL_EN
        send(4'hA, 7, 9, 4'h2);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("midmul_rst_valid", 64'(out_valid), 64'd0);
        sb.delete();
        mul_busy = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (W + 5) @(negedge clk);
        check("midmul_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_chk(4'h0, 5, 6, 4'h4, 11, 4'b0000, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
